axi_lite_uart: RTL

- AXI-Lite slave UART peripheral. It sits directly downstream of the core's m_axi_lite_* master port, which serves the uncached MMIO region.
- It provides memory-mapped TX and RX, an 8N1 serial line, a TX FIFO and a single-entry RX holding register.
- It has a programmable baud divisor and one level-sensitive interrupt output.

---
 rtl/axi_lite_uart.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_uart.sv
// axi_lite_uart: memory-mapped 8N1 UART behind an AXI-Lite slave port.
//
// Register map (addr[3:2]):
//   0x0 TXDATA  write pushes wdata[7:0] into the TX FIFO, reads 0
//   0x4 RXDATA  {23'b0, rx_valid, rx_byte}; reading clears rx_valid
//   0x8 STATUS  {27'b0, overrun, tx_busy, tx_full, tx_empty, rx_valid}; write clears overrun
//   0xC CTRL    {14'b0, ie_tx, ie_rx, baud_div}
//
// Ports:
//   aclk, aresetn         clock, async active-low reset
//   s_axi_lite_*          AXI-Lite slave (AW+W accepted together, single outstanding)
//   uart_tx / uart_rx     serial line (rx is asynchronous, synchronised here)
//   irq                   (rx_valid & ie_rx) | (tx_empty & ie_tx)
//
// TX and RX FSMs share the same state encoding:
//   state   | meaning
//   S_IDLE  | line idle (TX: waiting for FIFO data, RX: waiting for falling edge)
//   S_START | start bit (RX: counting to mid-bit for glitch check)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit
module axi_lite_uart #(
  parameter int          TX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic [3:0]  s_axi_lite_wstrb,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [31:0] s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic        wr_hs, rd_hs, wr_en;
  logic [1:0]  wr_sel, rd_sel;
  logic [31:0] rd_mux;
  logic [15:0] baud_div;
  logic        ie_rx, ie_tx;
  logic        rx_valid, overrun, rd_clr;
  logic [7:0]  rx_byte;

  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        tx_empty, tx_full, push, pop, tx_busy;

  state_t      tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shreg;

  state_t      rx_state;
  logic [1:0]  rx_sync;
  logic        rx_s, rx_prev, rx_done;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shreg;

  logic        unused_bits;
  assign unused_bits = ^{s_axi_lite_awaddr[31:4], s_axi_lite_awaddr[1:0],
                         s_axi_lite_araddr[31:4], s_axi_lite_araddr[1:0],
                         s_axi_lite_wdata[31:18], s_axi_lite_wstrb[3:1]};

  assign s_axi_lite_awready = s_axi_lite_awvalid & s_axi_lite_wvalid & ~s_axi_lite_bvalid;
  assign s_axi_lite_wready  = s_axi_lite_awready;
  assign s_axi_lite_arready = s_axi_lite_arvalid & ~s_axi_lite_rvalid;
  assign s_axi_lite_bresp   = 2'b00;
  assign s_axi_lite_rresp   = 2'b00;

  assign wr_hs  = s_axi_lite_awready;
  assign rd_hs  = s_axi_lite_arready;
  assign wr_sel = s_axi_lite_awaddr[3:2];
  assign rd_sel = s_axi_lite_araddr[3:2];
  assign wr_en  = wr_hs & s_axi_lite_wstrb[0];
  assign rd_clr = rd_hs & (rd_sel == 2'd1) & rx_valid;

  assign tx_empty = (wr_ptr == rd_ptr);
  assign tx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = (tx_state == S_IDLE) & ~tx_empty;
  // A full FIFO still accepts a byte when the TX side frees a slot this cycle.
  assign push     = wr_en & (wr_sel == 2'd0) & (~tx_full | pop);
  assign tx_busy  = (tx_state != S_IDLE);

  assign rx_s    = rx_sync[1];
  assign rx_done = (rx_state == S_STOP) && (rx_cnt == 16'd0) && rx_s;

  assign irq = (rx_valid & ie_rx) | (tx_empty & ie_tx);

  always_comb begin
    rd_mux = 32'd0;
    case (rd_sel)
      2'd1:    rd_mux = {23'd0, rx_valid, rx_byte};
      2'd2:    rd_mux = {27'd0, overrun, tx_busy, tx_full, tx_empty, rx_valid};
      2'd3:    rd_mux = {14'd0, ie_tx, ie_rx, baud_div};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= s_axi_lite_wdata[7:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_lite_bvalid <= 1'b0;
      s_axi_lite_rvalid <= 1'b0;
      s_axi_lite_rdata  <= 32'd0;
      baud_div          <= DEFAULT_DIV;
      ie_rx             <= 1'b0;
      ie_tx             <= 1'b0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      rx_valid          <= 1'b0;
      rx_byte           <= 8'd0;
      overrun           <= 1'b0;
    end else begin
      if (wr_hs) s_axi_lite_bvalid <= 1'b1;
      else if (s_axi_lite_bready) s_axi_lite_bvalid <= 1'b0;

      if (rd_hs) begin
        s_axi_lite_rvalid <= 1'b1;
        s_axi_lite_rdata  <= rd_mux;
      end else if (s_axi_lite_rready) begin
        s_axi_lite_rvalid <= 1'b0;
      end

      if (wr_en && wr_sel == 2'd3) begin
        baud_div <= (s_axi_lite_wdata[15:1] == 15'd0) ? 16'd2 : s_axi_lite_wdata[15:0];
        ie_rx    <= s_axi_lite_wdata[16];
        ie_tx    <= s_axi_lite_wdata[17];
      end

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      if (wr_en && wr_sel == 2'd2) overrun <= 1'b0;

      // A new byte beats a same-cycle read clear; otherwise the held byte is kept.
      if (rx_done) begin
        if (rx_valid && !rd_clr) begin
          overrun <= 1'b1;
        end else begin
          rx_byte  <= rx_shreg;
          rx_valid <= 1'b1;
        end
      end else if (rd_clr) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shreg <= 8'd0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (!tx_empty) begin
            tx_shreg <= fifo_mem[rd_ptr[AW-1:0]];
            tx_div   <= baud_div;
            tx_cnt   <= baud_div - 16'd1;
            uart_tx  <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt   <= tx_div - 16'd1;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_shreg[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= tx_div - 16'd1;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              uart_tx  <= tx_shreg[1];
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin
          if (tx_cnt == 16'd0) tx_state <= S_IDLE;
          else tx_cnt <= tx_cnt - 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_div   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shreg <= 8'd0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_div   <= baud_div;
            rx_cnt   <= {1'b0, baud_div[15:1]} - 16'd1;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s) begin
              rx_state <= S_IDLE;
            end else begin
              rx_cnt   <= rx_div - 16'd1;
              rx_bit   <= 3'd0;
              rx_state <= S_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shreg <= {rx_s, rx_shreg[7:1]};
            rx_cnt   <= rx_div - 16'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin
          if (rx_cnt == 16'd0) rx_state <= S_IDLE;
          else rx_cnt <= rx_cnt - 16'd1;
        end
      endcase
    end
  end

endmodule
